result_save_cfg_ctrl: RTL and testbench

//  Configures and sequences the conv result-save path for one layer. It computes the output-feature geometry
//  and write-address strides (o_feature_size, img2col_t_num, switch_kernel_group_addnums, switch_kernel_addnums)

---
 rtl/result_save_cfg_ctrl_pkg.sv | 27 ++
 rtl/result_save_cfg_ctrl_seq_divider.sv | 53 +++++
 rtl/result_save_cfg_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_result_save_cfg_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_save_cfg_ctrl_pkg.sv
// Shared definitions for the conv result-save configuration controller.
// Holds the default datapath widths, the controller state encoding and a
// small width helper used when comparing operands of different sizes.
package result_save_cfg_ctrl_pkg;

  localparam int TENSOR_SIZE = 8;
  localparam int KERNEL_SIZE = 4;
  localparam int STRIDE_SIZE = 4;
  localparam int ADDR_SIZE   = 16;
  localparam int S2P_SIZE    = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_DIV,
    ST_MUL,
    ST_ADDR,
    ST_RUN,
    ST_DONE,
    ST_ERR
  } cfg_state_t;

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/result_save_cfg_ctrl_seq_divider.sv
// Sequential divider by repeated subtraction: one subtract per cycle.
// A start pulse loads the dividend; done is raised in the first cycle in
// which the remainder is smaller than the divisor, so a quotient of q takes
// q+1 active cycles. The divisor must be non-zero and held stable.
module seq_divider
  import result_save_cfg_ctrl_pkg::*;
#(
  parameter int NW = 8,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [NW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          done,
  output logic [NW-1:0] quotient
);

  localparam int CW = max_w(NW, DW);

  logic [NW-1:0] rem;
  logic          active;
  logic [CW-1:0] rem_ext;
  logic [CW-1:0] div_ext;
  logic          can_sub;

  assign rem_ext = CW'(rem);
  assign div_ext = CW'(divisor);
  assign can_sub = (rem_ext >= div_ext);
  assign done    = active && !can_sub;

  // Load on start, then subtract once per cycle until the remainder runs out
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rem      <= '0;
      quotient <= '0;
      active   <= 1'b0;
    end else if (start) begin
      rem      <= dividend;
      quotient <= '0;
      active   <= 1'b1;
    end else if (active) begin
      if (can_sub) begin
        rem      <= NW'(rem_ext - div_ext);
        quotient <= quotient + NW'(1);
      end else begin
        active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/result_save_cfg_ctrl.sv
// Conv result-save configuration controller for one layer.
// Derives output-feature geometry and write-address strides from the layer
// shape, then counts GEMM tile completions, flags group-last tiles and
// pulses conv_done after the final tile.
// Optional feature: define RESULT_CFG_PERF_EN to add the run_cycles counter.
module result_save_cfg_ctrl
  import result_save_cfg_ctrl_pkg::*;
#(
  parameter int TS_W  = TENSOR_SIZE,
  parameter int KS_W  = KERNEL_SIZE,
  parameter int ST_W  = STRIDE_SIZE,
  parameter int AW    = ADDR_SIZE,
  parameter int S2P   = S2P_SIZE,
  parameter int GRP_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cfg_start,
  input  logic [TS_W-1:0]  tensor_size,
  input  logic [KS_W-1:0]  kernel_size,
  input  logic [ST_W-1:0]  stride,
  input  logic [GRP_W-1:0] kernel_groups,
  input  logic             tile_done,
  output logic             cfg_busy,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic [AW-1:0]    o_feature_size,
  output logic [AW-1:0]    img2col_t_num,
  output logic [AW-1:0]    switch_kernel_group_addnums,
  output logic [AW-1:0]    switch_kernel_addnums,
  output logic             tile_last_in_group,
  output logic             conv_done
`ifdef RESULT_CFG_PERF_EN
  ,
  output logic [31:0]      run_cycles
`endif
);

  localparam int LG = $clog2(S2P);
  localparam int CW = max_w(TS_W, KS_W);

  cfg_state_t state;
  cfg_state_t next_state;

  logic [TS_W-1:0]  t_r;
  logic [KS_W-1:0]  k_r;
  logic [ST_W-1:0]  s_r;
  logic [GRP_W-1:0] g_r;

  logic [CW-1:0]    t_ext;
  logic [CW-1:0]    k_ext;
  logic [TS_W-1:0]  div_dividend;
  logic             shape_err;
  logic             div_start;
  logic             div_done;
  logic [TS_W-1:0]  div_quo;

  logic [TS_W:0]    o_dim;
  logic [AW-1:0]    o_dim_a;
  logic [AW-1:0]    ofs_w;
  logic [AW-1:0]    tnum_w;
  logic [AW-1:0]    ofs_r;
  logic [AW-1:0]    tnum_r;
  logic [AW-1:0]    grp_w;
  logic [AW-1:0]    kern_w;
  logic             addr_err;

  logic [AW-1:0]    tile_idx;
  logic [GRP_W-1:0] grp_idx;
  logic             tile_last;
  logic             grp_last;

  assign t_ext        = CW'(tensor_size_latched());
  assign k_ext        = CW'(k_r);
  assign shape_err    = (s_r == '0) || (k_ext > t_ext) || (g_r == '0);
  assign div_dividend = TS_W'(t_ext - k_ext);
  assign div_start    = (state == ST_CHECK) && !shape_err;

  function automatic logic [TS_W-1:0] tensor_size_latched();
    return t_r;
  endfunction

  seq_divider #(
    .NW (TS_W),
    .DW (ST_W)
  ) u_div (
    .clk      (clk),
    .rstn     (rstn),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (s_r),
    .done     (div_done),
    .quotient (div_quo)
  );

  // The low AW bits of the wide square equal the AW-bit product, so the
  // multiply is done directly at AW bits.
  assign o_dim   = {1'b0, div_quo} + (TS_W + 1)'(1);
  assign o_dim_a = AW'(o_dim);
  assign ofs_w   = o_dim_a * o_dim_a;
  assign tnum_w  = (ofs_w >> LG) + AW'(|ofs_w[LG-1:0]);

  assign grp_w    = (ofs_r << LG) - ((tnum_r - AW'(1)) << LG);
  assign kern_w   = ofs_r - AW'(S2P - 1);
  assign addr_err = (ofs_r < AW'(S2P - 1));

  assign tile_last = (tile_idx == img2col_t_num - AW'(1));
  assign grp_last  = (grp_idx == g_r - GRP_W'(1));

  // Capture the layer shape whenever a new configuration is requested
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      t_r <= '0;
      k_r <= '0;
      s_r <= '0;
      g_r <= '0;
    end else if (cfg_start) begin
      t_r <= tensor_size;
      k_r <= kernel_size;
      s_r <= stride;
      g_r <= kernel_groups;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state logic; a new cfg_start always aborts and restarts the check
  always_comb begin
    next_state = state;
    if (cfg_start) begin
      next_state = ST_CHECK;
    end else begin
      case (state)
        ST_IDLE:  next_state = ST_IDLE;
        ST_CHECK: next_state = shape_err ? ST_ERR : ST_DIV;
        ST_DIV:   if (div_done) next_state = ST_MUL;
        ST_MUL:   next_state = ST_ADDR;
        ST_ADDR:  next_state = addr_err ? ST_ERR : ST_RUN;
        ST_RUN:   if (tile_done && tile_last && grp_last) next_state = ST_DONE;
        ST_DONE:  next_state = ST_IDLE;
        ST_ERR:   next_state = ST_ERR;
        default:  next_state = ST_IDLE;
      endcase
    end
  end

  // Status outputs decoded from the current state
  always_comb begin
    cfg_busy           = (state == ST_CHECK) || (state == ST_DIV) ||
                         (state == ST_MUL)   || (state == ST_ADDR);
    cfg_ready          = (state == ST_RUN);
    cfg_err            = (state == ST_ERR);
    conv_done          = (state == ST_DONE);
    tile_last_in_group = (state == ST_RUN) && tile_last;
  end

  // Hold the square and tile count between MUL and ADDR
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ofs_r  <= '0;
      tnum_r <= '0;
    end else if (state == ST_MUL) begin
      ofs_r  <= ofs_w;
      tnum_r <= tnum_w;
    end
  end

  // Geometry outputs update only when RUN is entered and are zeroed on error
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_feature_size              <= '0;
      img2col_t_num               <= '0;
      switch_kernel_group_addnums <= '0;
      switch_kernel_addnums       <= '0;
    end else if (state == ST_ADDR && next_state == ST_RUN) begin
      o_feature_size              <= ofs_r;
      img2col_t_num               <= tnum_r;
      switch_kernel_group_addnums <= grp_w;
      switch_kernel_addnums       <= kern_w;
    end else if (state != ST_ERR && next_state == ST_ERR) begin
      o_feature_size              <= '0;
      img2col_t_num               <= '0;
      switch_kernel_group_addnums <= '0;
      switch_kernel_addnums       <= '0;
    end
  end

  // Tile and group counters, live only in RUN and cleared on any restart
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tile_idx <= '0;
      grp_idx  <= '0;
    end else if (state != ST_RUN || cfg_start) begin
      tile_idx <= '0;
      grp_idx  <= '0;
    end else if (tile_done) begin
      if (tile_last) begin
        tile_idx <= '0;
        grp_idx  <= grp_idx + GRP_W'(1);
      end else begin
        tile_idx <= tile_idx + AW'(1);
      end
    end
  end

`ifdef RESULT_CFG_PERF_EN
  // Count cycles spent in RUN; value is kept after the layer completes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_cycles <= '0;
    end else if (state != ST_RUN && next_state == ST_RUN) begin
      run_cycles <= '0;
    end else if (state == ST_RUN) begin
      run_cycles <= run_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_result_save_cfg_ctrl.sv
// Self-checking bench for result_save_cfg_ctrl.
// Table of layer shapes with hand-computed geometry, plus directed sequences
// for abort, reset during division, start/final-tile collision and the
// optional RESULT_CFG_PERF_EN cycle counter.
module tb_result_save_cfg_ctrl;
  import result_save_cfg_ctrl_pkg::*;

  localparam int TS_W  = TENSOR_SIZE;
  localparam int KS_W  = KERNEL_SIZE;
  localparam int ST_W  = STRIDE_SIZE;
  localparam int AW    = ADDR_SIZE;
  localparam int GRP_W = 8;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             cfg_start = 1'b0;
  logic [TS_W-1:0]  tensor_size = '0;
  logic [KS_W-1:0]  kernel_size = '0;
  logic [ST_W-1:0]  stride = '0;
  logic [GRP_W-1:0] kernel_groups = '0;
  logic             tile_done = 1'b0;
  logic             cfg_busy;
  logic             cfg_ready;
  logic             cfg_err;
  logic [AW-1:0]    o_feature_size;
  logic [AW-1:0]    img2col_t_num;
  logic [AW-1:0]    switch_kernel_group_addnums;
  logic [AW-1:0]    switch_kernel_addnums;
  logic             tile_last_in_group;
  logic             conv_done;
`ifdef RESULT_CFG_PERF_EN
  logic [31:0]      run_cycles;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    int t; int k; int s; int g;
    bit err; int lat;
    int ofs; int tnum; int grp; int kern;
  } vec_t;

  vec_t vecs[8];

  result_save_cfg_ctrl dut (
    .clk                         (clk),
    .rstn                        (rstn),
    .cfg_start                   (cfg_start),
    .tensor_size                 (tensor_size),
    .kernel_size                 (kernel_size),
    .stride                      (stride),
    .kernel_groups               (kernel_groups),
    .tile_done                   (tile_done),
    .cfg_busy                    (cfg_busy),
    .cfg_ready                   (cfg_ready),
    .cfg_err                     (cfg_err),
    .o_feature_size              (o_feature_size),
    .img2col_t_num               (img2col_t_num),
    .switch_kernel_group_addnums (switch_kernel_group_addnums),
    .switch_kernel_addnums       (switch_kernel_addnums),
    .tile_last_in_group          (tile_last_in_group),
    .conv_done                   (conv_done)
`ifdef RESULT_CFG_PERF_EN
    ,
    .run_cycles                  (run_cycles)
`endif
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Hard stop in case a sequence wedges
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive a shape with a cfg_start pulse; call just after a falling edge
  task automatic apply_stimulus(input int t, input int k, input int s, input int g);
    tensor_size   = TS_W'(t);
    kernel_size   = KS_W'(k);
    stride        = ST_W'(s);
    kernel_groups = GRP_W'(g);
    cfg_start     = 1'b1;
  endtask

  // Wait for ready or error; lat counts rising edges since cfg_start
  task automatic wait_result(input int limit, output int lat, output bit seen_done);
    lat = 0;
    seen_done = 1'b0;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk);
      cfg_start = 1'b0;
      if (conv_done) seen_done = 1'b1;
      if (cfg_ready || cfg_err) begin
        lat = n;
        break;
      end
    end
    check_output("result_within_bound", 32'(lat != 0), 32'd1);
  endtask

  // Pulse tile_done back to back, checking group-last flags and conv_done
  task automatic run_tiles(input int tnum, input int g);
    int total;
    total = tnum * g;
    for (int i = 0; i < total; i++) begin
      check_output("tile_last_in_group", 32'(tile_last_in_group), 32'((i % tnum) == tnum - 1));
      tile_done = 1'b1;
      @(negedge clk);
      tile_done = 1'b0;
      check_output("conv_done_pulse", 32'(conv_done), 32'(i == total - 1));
      check_output("cfg_ready_run", 32'(cfg_ready), 32'(i != total - 1));
    end
    @(negedge clk);
    check_output("conv_done_single", 32'(conv_done), 32'd0);
    check_output("tile_last_idle", 32'(tile_last_in_group), 32'd0);
  endtask

  task automatic check_geometry(input string tag, input int ofs, input int tnum, input int grp, input int kern);
    check_output({tag, "_ofs"},  32'(o_feature_size), 32'(ofs));
    check_output({tag, "_tnum"}, 32'(img2col_t_num), 32'(tnum));
    check_output({tag, "_grp"},  32'(switch_kernel_group_addnums), 32'(grp));
    check_output({tag, "_kern"}, 32'(switch_kernel_addnums), 32'(kern));
  endtask

  initial begin
    int  lat;
    bit  seen;

    vecs[0] = '{t: 8,  k: 3, s: 1, g: 2, err: 0, lat: 10, ofs: 36,  tnum: 5,  grp: 256,  kern: 29};
    vecs[1] = '{t: 3,  k: 5, s: 1, g: 1, err: 1, lat: 2,  ofs: 0,   tnum: 0,  grp: 0,    kern: 0};
    vecs[2] = '{t: 7,  k: 3, s: 2, g: 1, err: 0, lat: 7,  ofs: 9,   tnum: 2,  grp: 64,   kern: 2};
    vecs[3] = '{t: 8,  k: 3, s: 0, g: 1, err: 1, lat: 2,  ofs: 0,   tnum: 0,  grp: 0,    kern: 0};
    vecs[4] = '{t: 16, k: 3, s: 1, g: 1, err: 0, lat: 18, ofs: 196, tnum: 25, grp: 1376, kern: 189};
    vecs[5] = '{t: 4,  k: 3, s: 1, g: 1, err: 1, lat: 6,  ofs: 0,   tnum: 0,  grp: 0,    kern: 0};
    vecs[6] = '{t: 6,  k: 3, s: 1, g: 3, err: 0, lat: 8,  ofs: 16,  tnum: 2,  grp: 120,  kern: 9};
    vecs[7] = '{t: 8,  k: 3, s: 1, g: 0, err: 1, lat: 2,  ofs: 0,   tnum: 0,  grp: 0,    kern: 0};

    // Reset state
    repeat (2) @(negedge clk);
    check_output("reset_busy",  32'(cfg_busy), 32'd0);
    check_output("reset_ready", 32'(cfg_ready), 32'd0);
    check_output("reset_err",   32'(cfg_err), 32'd0);
    check_output("reset_done",  32'(conv_done), 32'd0);
    check_output("reset_last",  32'(tile_last_in_group), 32'd0);
    check_geometry("reset", 0, 0, 0, 0);
    rstn = 1'b1;
    @(negedge clk);

    // Table of shapes
    for (int v = 0; v < 8; v++) begin
      $display("[TB] vector %0d: T=%0d K=%0d S=%0d G=%0d", v, vecs[v].t, vecs[v].k, vecs[v].s, vecs[v].g);
      apply_stimulus(vecs[v].t, vecs[v].k, vecs[v].s, vecs[v].g);
      wait_result(100, lat, seen);
      check_output("latency", 32'(lat), 32'(vecs[v].lat));
      check_output("cfg_err", 32'(cfg_err), 32'(vecs[v].err));
      check_output("cfg_busy_after", 32'(cfg_busy), 32'd0);
      check_geometry("table", vecs[v].ofs, vecs[v].tnum, vecs[v].grp, vecs[v].kern);
      if (!vecs[v].err) begin
        run_tiles(vecs[v].tnum, vecs[v].g);
        check_geometry("held", vecs[v].ofs, vecs[v].tnum, vecs[v].grp, vecs[v].kern);
      end else begin
        repeat (3) @(negedge clk);
        check_output("err_sticky", 32'(cfg_err), 32'd1);
      end
    end

    // Abort mid-RUN after 3 tiles, restart with a new shape
    $display("[TB] abort sequence");
    apply_stimulus(8, 3, 1, 2);
    wait_result(100, lat, seen);
    for (int i = 0; i < 3; i++) begin
      tile_done = 1'b1;
      @(negedge clk);
      tile_done = 1'b0;
    end
    apply_stimulus(7, 3, 2, 1);
    wait_result(100, lat, seen);
    check_output("abort_no_done", 32'(seen), 32'd0);
    check_output("abort_latency", 32'(lat), 32'd7);
    check_geometry("abort", 9, 2, 64, 2);
    run_tiles(2, 1);

    // cfg_start together with the final tile_done: restart wins
    $display("[TB] start/final-tile collision");
    apply_stimulus(7, 3, 2, 1);
    wait_result(100, lat, seen);
    tile_done = 1'b1;
    @(negedge clk);
    apply_stimulus(7, 3, 2, 1);
    @(negedge clk);
    tile_done = 1'b0;
    cfg_start = 1'b0;
    check_output("collide_no_done", 32'(conv_done), 32'd0);
    check_output("collide_busy", 32'(cfg_busy), 32'd1);
    wait_result(100, lat, seen);
    check_output("collide_ready", 32'(cfg_ready), 32'd1);
    run_tiles(2, 1);

    // Asynchronous reset while dividing
    $display("[TB] reset during DIV");
    apply_stimulus(8, 3, 1, 2);
    repeat (4) @(negedge clk);
    cfg_start = 1'b0;
    check_output("div_busy", 32'(cfg_busy), 32'd1);
    rstn = 1'b0;
    #1;
    check_output("rst_busy", 32'(cfg_busy), 32'd0);
    check_output("rst_ready", 32'(cfg_ready), 32'd0);
    check_geometry("rst", 0, 0, 0, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    tile_done = 1'b1;
    @(negedge clk);
    tile_done = 1'b0;
    check_output("idle_tile_ignored", 32'(conv_done), 32'd0);
    apply_stimulus(8, 3, 1, 2);
    @(negedge clk);
    cfg_start = 1'b0;
    tile_done = 1'b1;
    @(negedge clk);
    tile_done = 1'b0;
    wait_result(100, lat, seen);
    check_geometry("post_rst", 36, 5, 256, 29);
    run_tiles(5, 2);

`ifdef RESULT_CFG_PERF_EN
    // One tile every 4 cycles over 10 tiles
    $display("[TB] run_cycles counter");
    apply_stimulus(8, 3, 1, 2);
    wait_result(100, lat, seen);
    for (int i = 0; i < 10; i++) begin
      tile_done = 1'b1;
      @(negedge clk);
      tile_done = 1'b0;
      if (i != 9) repeat (3) @(negedge clk);
    end
    check_output("perf_done", 32'(conv_done), 32'd1);
    check_output("run_cycles_done", run_cycles, 32'd37);
    repeat (3) @(negedge clk);
    check_output("run_cycles_hold", run_cycles, 32'd37);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
